// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file widths, address type and zero-register constant
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_N_DEF  = 32;
    localparam int ADDR_W_DEF = $clog2(REG_N_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy bits with issue-set over writeback-clear over flush
module reg_scoreboard
    import mips_pkg::*;
#(
    parameter int REG_N  = REG_N_DEF,
    parameter int ADDR_W = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_reg,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_reg,
    input  logic              flush,
    output logic [REG_N-1:0]  busy
);

    logic [REG_N-1:0] busy_next;

    // Later assignments win: flush, then writeback clear, then issue set.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end
        if (clr_en) begin
            busy_next[clr_reg] = 1'b0;
        end
        if (set_en && (set_reg != ADDR_W'(ZERO_REG))) begin
            busy_next[set_reg] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - two-read one-write register file with busy scoreboard
// Optional write-through read path when REG_FILE_BYPASS_EN is defined.
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_N  = REG_N_DEF,
    parameter int ADDR_W = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteW,
    input  logic [ADDR_W-1:0] WriteRegW,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [ADDR_W-1:0] RdAddr1,
    input  logic [ADDR_W-1:0] RdAddr2,
    output logic [DATA_W-1:0] RdData1,
    output logic [DATA_W-1:0] RdData2,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueReg,
    input  logic              Flush,
    output logic              Busy1,
    output logic              Busy2
);

    logic [DATA_W-1:0] regs [REG_N];
    logic [REG_N-1:0]  busy;
    logic              write_en;

    assign write_en = RegWriteW && (WriteRegW != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[WriteRegW] <= ResultW;
        end
    end

    reg_scoreboard #(
        .REG_N  (REG_N),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en  (IssueValid),
        .set_reg (IssueReg),
        .clr_en  (RegWriteW),
        .clr_reg (WriteRegW),
        .flush   (Flush),
        .busy    (busy)
    );

    always_comb begin
        RdData1 = (RdAddr1 == ADDR_W'(ZERO_REG)) ? '0 : regs[RdAddr1];
        RdData2 = (RdAddr2 == ADDR_W'(ZERO_REG)) ? '0 : regs[RdAddr2];
        Busy1   = busy[RdAddr1];
        Busy2   = busy[RdAddr2];
`ifdef REG_FILE_BYPASS_EN
        if (write_en && (WriteRegW == RdAddr1)) begin
            RdData1 = ResultW;
            Busy1   = 1'b0;
        end
        if (write_en && (WriteRegW == RdAddr2)) begin
            RdData2 = ResultW;
            Busy2   = 1'b0;
        end
`endif
        // The bypass path must not leak ResultW while reset holds the outputs at zero.
        if (reset) begin
            RdData1 = '0;
            RdData2 = '0;
            Busy1   = 1'b0;
            Busy2   = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file (honours REG_FILE_BYPASS_EN)
`timescale 1ns/1ps
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic [4:0]  RdAddr1, RdAddr2;
    logic [31:0] RdData1, RdData2;
    logic        IssueValid;
    logic [4:0]  IssueReg;
    logic        Flush;
    logic        Busy1, Busy2;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteW  (RegWriteW),
        .WriteRegW  (WriteRegW),
        .ResultW    (ResultW),
        .RdAddr1    (RdAddr1),
        .RdAddr2    (RdAddr2),
        .RdData1    (RdData1),
        .RdData2    (RdData2),
        .IssueValid (IssueValid),
        .IssueReg   (IssueReg),
        .Flush      (Flush),
        .Busy1      (Busy1),
        .Busy2      (Busy2)
    );

    always #5 clk = ~clk;

    // Architectural model: plain arrays updated by the rules for one edge.
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (RegWriteW && WriteRegW != 0) m_regs[WriteRegW] = ResultW;
            if (Flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            if (RegWriteW) m_busy[WriteRegW] = 1'b0;
            if (IssueValid && IssueReg != 0) m_busy[IssueReg] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (reset || a == 0) return 32'h0;
        if (BYPASS && RegWriteW && WriteRegW == a) return ResultW;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (reset || a == 0) return 1'b0;
        if (BYPASS && RegWriteW && WriteRegW == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " rd1"}, RdData1, exp_data(RdAddr1));
        check({tag, " rd2"}, RdData2, exp_data(RdAddr2));
        check({tag, " busy1"}, {31'h0, Busy1}, {31'h0, exp_busy(RdAddr1)});
        check({tag, " busy2"}, {31'h0, Busy2}, {31'h0, exp_busy(RdAddr2)});
    endtask

    always @(negedge clk) check_model("cycle");

    task automatic idle();
        RegWriteW  = 1'b0;
        IssueValid = 1'b0;
        Flush      = 1'b0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        WriteRegW = 0; ResultW = 0; IssueReg = 0; RdAddr1 = 0; RdAddr2 = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        RdAddr1 = 5'd5; RdAddr2 = 5'd7;
        #1;
        check("reset rd1", RdData1, 32'h0);
        check("reset busy2", {31'h0, Busy2}, 32'h0);

        // Write R5 then read it back.
        RegWriteW = 1'b1; WriteRegW = 5'd5; ResultW = 32'h12345678;
        edge_step();
        RdAddr1 = 5'd5;
        @(negedge clk);
        check("r5 read", RdData1, 32'h12345678);

        // R0 is hard-wired: writes and issues to it are ignored.
        RegWriteW = 1'b1; WriteRegW = 5'd0; ResultW = 32'hFFFFFFFF;
        IssueValid = 1'b1; IssueReg = 5'd0; RdAddr2 = 5'd0;
        @(negedge clk);
        check("r0 same cycle", RdData2, 32'h0);
        edge_step();
        @(negedge clk);
        check("r0 read", RdData2, 32'h0);
        check("r0 busy", {31'h0, Busy2}, 32'h0);

        // R7 busy from issue to writeback; a same-edge re-issue keeps it busy.
        IssueValid = 1'b1; IssueReg = 5'd7; RdAddr1 = 5'd7;
        edge_step();
        repeat (2) begin
            @(negedge clk);
            check("r7 busy held", {31'h0, Busy1}, 32'h1);
        end
        RegWriteW = 1'b1; WriteRegW = 5'd7; ResultW = 32'h77;
        IssueValid = 1'b1; IssueReg = 5'd7;
        edge_step();
        @(negedge clk);
        check("r7 reissue busy", {31'h0, Busy1}, 32'h1);
        check("r7 data", RdData1, 32'h77);
        RegWriteW = 1'b1; WriteRegW = 5'd7; ResultW = 32'h78;
        edge_step();
        @(negedge clk);
        check("r7 cleared", {31'h0, Busy1}, 32'h0);

        // Flush squashes R3/R9; same-edge writeback of R3 still lands.
        IssueValid = 1'b1; IssueReg = 5'd3;
        edge_step();
        IssueValid = 1'b1; IssueReg = 5'd9;
        edge_step();
        RdAddr1 = 5'd3; RdAddr2 = 5'd9;
        @(negedge clk);
        check("r3 busy", {31'h0, Busy1}, 32'h1);
        check("r9 busy", {31'h0, Busy2}, 32'h1);
        Flush = 1'b1; RegWriteW = 1'b1; WriteRegW = 5'd3; ResultW = 32'hA5;
        edge_step();
        @(negedge clk);
        check("flush r3 busy", {31'h0, Busy1}, 32'h0);
        check("flush r9 busy", {31'h0, Busy2}, 32'h0);
        check("flush wb r3", RdData1, 32'hA5);
        Flush = 1'b1; IssueValid = 1'b1; IssueReg = 5'd9;
        edge_step();
        @(negedge clk);
        check("flush issue r9", {31'h0, Busy2}, 32'h1);

        // Same-cycle write and read of R4.
        RegWriteW = 1'b1; WriteRegW = 5'd4; ResultW = 32'h1111;
        IssueValid = 1'b1; IssueReg = 5'd4;
        edge_step();
        RdAddr1 = 5'd4;
        RegWriteW = 1'b1; WriteRegW = 5'd4; ResultW = 32'hDEAD;
        @(negedge clk);
        check("r4 same-cycle data", RdData1, BYPASS ? 32'hDEAD : 32'h1111);
        check("r4 same-cycle busy", {31'h0, Busy1}, BYPASS ? 32'h0 : 32'h1);
        edge_step();
        @(negedge clk);
        check("r4 after data", RdData1, 32'hDEAD);
        check("r4 after busy", {31'h0, Busy1}, 32'h0);

        // Fill R1..R31, mark a few busy, then reset away from any edge.
        for (int i = 1; i < 32; i++) begin
            RegWriteW = 1'b1; WriteRegW = 5'(i); ResultW = 32'h01010101 * i;
            IssueValid = (i % 3 == 0); IssueReg = 5'(i + 1);
            edge_step();
        end
        RdAddr1 = 5'd10; RdAddr2 = 5'd31;
        @(negedge clk);
        check("fill r10", RdData1, 32'h0A0A0A0A);
        check("fill r31", RdData2, 32'h1F1F1F1F);
        @(posedge clk);
        #3 reset = 1'b1;
        RegWriteW = 1'b1; ResultW = 32'hCAFEF00D; IssueValid = 1'b1;
        for (int i = 1; i < 32; i++) begin
            RdAddr1 = 5'(i); RdAddr2 = 5'(32 - i);
            WriteRegW = 5'(i); IssueReg = 5'(i);
            #1;
            check("reset rd1", RdData1, 32'h0);
            check("reset rd2", RdData2, 32'h0);
            check("reset busy1", {31'h0, Busy1}, 32'h0);
            check("reset busy2", {31'h0, Busy2}, 32'h0);
        end
        @(negedge clk);
        idle();
        #2 reset = 1'b0;
        for (int i = 1; i < 32; i += 6) begin
            RdAddr1 = 5'(i); RdAddr2 = 5'(i + 1);
            @(negedge clk);
            check("post-reset rd1", RdData1, 32'h0);
            check("post-reset busy1", {31'h0, Busy1}, 32'h0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
